// File: rtl/crc_pkg.sv
// Shared definitions for the CRC link: FSM state encoding, default CRC-8
// polynomial and init value, and the default payload/CRC width pair.
// The receiver side imports the same package so both ends agree.
package crc_pkg;

  localparam int BW_DEFAULT     = 40;
  localparam int CRC_BW_DEFAULT = 8;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit combinational LFSR update: shifts one message bit into a
// CRC_BW-wide CRC register, MSB first, modulo-2, overflow discarded.
// Reusable by the receiver checker.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int                CRC_BW = CRC_BW_DEFAULT,
  parameter logic [CRC_BW-1:0] POLY   = CRC_BW'(CRC8_POLY)
) (
  input  logic [CRC_BW-1:0] crc_i,
  input  logic              bit_i,
  output logic [CRC_BW-1:0] crc_o
);

  logic fb;

  // Feedback is the bit leaving the register XORed with the incoming message bit.
  assign fb    = crc_i[CRC_BW-1] ^ bit_i;
  assign crc_o = {crc_i[CRC_BW-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/crc_transmitter.sv
// Bit-serial CRC encoder: accepts a BW-bit payload, runs it MSB first
// through an LFSR one bit per clock, then presents {payload, crc}.
// Optional macro CRC_TX_ERR_INJECT_EN adds err_en/err_mask ports that XOR a
// latched mask onto the codeword (CRC is still computed on the clean payload).
module crc_transmitter
  import crc_pkg::*;
#(
  parameter int                BW     = BW_DEFAULT,
  parameter int                CRC_BW = CRC_BW_DEFAULT,
  parameter logic [CRC_BW-1:0] POLY   = CRC_BW'(CRC8_POLY),
  parameter logic [CRC_BW-1:0] INIT   = CRC_BW'(CRC8_INIT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BW-1:0]        in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BW+CRC_BW-1:0] out,
`ifdef CRC_TX_ERR_INJECT_EN
  input  logic                 err_en,
  input  logic [BW+CRC_BW-1:0] err_mask,
`endif
  output logic                 busy
);

  localparam int CW    = BW + CRC_BW;
  localparam int CNT_W = (BW > 1) ? $clog2(BW) : 1;

  crc_state_e        state_q, state_d;
  logic [BW-1:0]     shift_q, shift_d;
  logic [BW-1:0]     hold_q,  hold_d;
  logic [CRC_BW-1:0] crc_q,   crc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [CRC_BW-1:0] crc_step;
  logic [CW-1:0]     mask_q,  mask_d;

  crc_lfsr_step #(
    .CRC_BW (CRC_BW),
    .POLY   (POLY)
  ) u_step (
    .crc_i (crc_q),
    .bit_i (shift_q[BW-1]),
    .crc_o (crc_step)
  );

  // Next-state and datapath update for the IDLE/CALC/DONE sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in;
          hold_d  = in;
          crc_d   = INIT;
          cnt_d   = CNT_W'(BW - 1);
`ifdef CRC_TX_ERR_INJECT_EN
          mask_d  = err_en ? err_mask : '0;
`else
          mask_d  = '0;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        crc_d   = crc_step;
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any payload or CRC in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the payload copy and CRC are reset too, since they drive out directly and out must read zero after reset.
      state_q <= IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // Handshake outputs decode state only; the codeword comes straight from registers.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign out       = {hold_q, crc_q} ^ mask_q;

endmodule
